rgb_fader: RTL
==============

// Module: rgb_fader
// PURPOSE
//  Slew-rate limiter between the three rotary-encoder value registers and the PWM generators.
//  - Takes three WIDTH-bit target levels, one per colour channel.
//  - Moves three output levels toward their targets by at most STEP counts per update tick.
//  - Encoder jumps become smooth LED fades.
//  - One shared add/compare datapath, time-multiplexed across the channels by a small FSM.
// PARAMETERS
//  WIDTH     8   bit width of targets and levels (matches encoder/pwm WIDTH)
//  STEP_DIV  64  clk cycles between update ticks; must be >= 4
//  STEP      1   max change per channel per tick; 1 <= STEP <= 2**WIDTH-1
// PORTS
//  clk       in   1        system clock (the divided design clock); single clock domain
//  reset     in   1        synchronous, active-high reset
//  target0   in   WIDTH    channel 0 requested level (from encoder0)
//  target1   in   WIDTH    channel 1 requested level (from encoder1)
//  target2   in   WIDTH    channel 2 requested level (from encoder2)
//  enable    in   1        1 = fade; 0 = freeze levels, tick counter keeps running
//  level0    out  WIDTH    channel 0 level to pwm0, registered
//  level1    out  WIDTH    channel 1 level to pwm1, registered
//  level2    out  WIDTH    channel 2 level to pwm2, registered
//  busy      out  1        1 while FSM is in any UPD state
//  settled   out  1        registered; 1 when all levels equal their targets at last sweep
// BEHAVIOUR
//  Reset (reset=1 at posedge):
//  - level0..2=0, busy=0, settled=0, tick counter=0, FSM=IDLE.
//  Tick counter:
//  - Counts 0..STEP_DIV-1, then wraps.
//  - tick=1 for one cycle when count==STEP_DIV-1.
//  FSM states:
//  - IDLE: on tick && enable -> UPD0; otherwise stay. tick with enable=0 is dropped.
//  - UPD0, UPD1, UPD2: each lasts one cycle; UPD0->UPD1->UPD2->IDLE.
//  - busy=1 in UPD0..2.
//  - STEP_DIV>=4 guarantees a sweep ends before the next tick. No tick is ever queued.
//  Per-channel update, state UPDn, registered at the end of that cycle:
//  - Target sampled in that cycle; target changes at any time take effect at the next sample.
//  - diff = targetn - leveln, computed at WIDTH+1 bits signed. No wrap-around, ever.
//  - |diff| <= STEP: leveln <= targetn (exact landing, no overshoot).
//  - diff > STEP: leveln <= leveln + STEP.
//  - diff < -STEP: leveln <= leveln - STEP.
//  - Channels not in their UPD state hold their value.
//  Latency:
//  - level0 changes 1 cycle after tick, level1 after 2 cycles, level2 after 3 cycles.
//  - Full-scale fade time = ceil((2**WIDTH-1)/STEP) ticks.
//  settled:
//  - Updated only on the UPD2->IDLE transition.
//  - Set to 1 iff all three post-update levels equal the targets sampled in the sweep.
//  - Holds between sweeps.
//  Reset mid-sweep: aborts at once; state is as after reset; no partial update survives.
//  enable dropped mid-sweep: the sweep completes (enable is checked only in IDLE).
//  Target equal to level: level is unchanged. settled may still assert.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE, UPD0, UPD1, UPD2) as localparams/typedef.
//  - Shared package: NUM_CH=3 constant.
//  - Sub-module fade_step (combinational): inputs level, target, STEP; output next level.
//    One instance, its inputs muxed by FSM state.
//  - Top holds the tick counter, FSM, level registers and settled register.
// TESTING
//  1. Reset, then targets=0.
//     -> levels stay 0; settled=1 after the first sweep; busy is high exactly 3 cycles per tick.
//  2. STEP=1, target0 steps 0->10.
//     -> level0 reaches 10 after 10 ticks, rising by 1 per tick; level1/2 stay 0.
//  3. STEP=16, level1=250, target1=255.
//     -> level1=255 in one tick (no overshoot, no wrap).
//     Then target1=0 -> 255,239,... reaches 0 after 16 ticks.
//  4. Change target2 during UPD0 of a sweep.
//     -> new value used in UPD2 of the same sweep; settled reflects it.
//  5. enable=0 with target0=200, level0=50.
//     -> level0 frozen for 5 ticks; enable=1 resumes +STEP per tick.
//  6. Assert reset during UPD1.
//     -> next cycle: all levels 0, busy=0, settled=0, counter=0.

Source files
------------

// File: rtl/rgb_fader_pkg.sv
// Shared definitions for the rgb_fader slew limiter: channel count and sweep FSM states.
package rgb_fader_pkg;

  localparam int unsigned NUM_CH = 3;

  typedef enum logic [1:0] {
    IDLE,
    UPD0,
    UPD1,
    UPD2
  } state_t;

endpackage

// File: rtl/rgb_fader_fade_step.sv
// Combinational single-channel step: moves level toward target by at most STEP,
// landing exactly on target when within reach.
module fade_step #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] level,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] next_level
);

  localparam logic signed [WIDTH:0] STEP_S = (WIDTH+1)'(STEP);

  logic signed [WIDTH:0] diff;

  // One extra bit keeps the difference signed so the step never wraps.
  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, level});
    if (diff > STEP_S) begin
      next_level = level + WIDTH'(STEP);
    end else if (diff < -STEP_S) begin
      next_level = level - WIDTH'(STEP);
    end else begin
      next_level = target;
    end
  end

endmodule

// File: rtl/rgb_fader.sv
// Three-channel slew-rate limiter: a tick-driven FSM sweeps one shared fade_step
// datapath across the channels, one channel per cycle.
module rgb_fader
  import rgb_fader_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEP_DIV = 64,
  parameter int unsigned STEP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] target0,
  input  logic [WIDTH-1:0] target1,
  input  logic [WIDTH-1:0] target2,
  input  logic             enable,
  output logic [WIDTH-1:0] level0,
  output logic [WIDTH-1:0] level1,
  output logic [WIDTH-1:0] level2,
  output logic             busy,
  output logic             settled
);

  localparam int unsigned CNT_W = $clog2(STEP_DIV);

  logic [CNT_W-1:0]  cnt;
  logic              tick;
  state_t            state, state_nx;
  logic [WIDTH-1:0]  lvl [NUM_CH];
  logic [WIDTH-1:0]  tgt [NUM_CH];
  logic [NUM_CH-1:0] match, match_nx;
  logic [1:0]        ch;
  logic              upd;
  logic [WIDTH-1:0]  cur_lvl, cur_tgt, nxt_lvl;

  assign tgt[0] = target0;
  assign tgt[1] = target1;
  assign tgt[2] = target2;
  assign level0 = lvl[0];
  assign level1 = lvl[1];
  assign level2 = lvl[2];

  assign tick = (cnt == CNT_W'(STEP_DIV - 1));
  assign busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    upd      = 1'b0;
    ch       = 2'd0;
    case (state)
      IDLE: if (tick && enable) state_nx = UPD0;
      UPD0: begin upd = 1'b1; ch = 2'd0; state_nx = UPD1; end
      UPD1: begin upd = 1'b1; ch = 2'd1; state_nx = UPD2; end
      UPD2: begin upd = 1'b1; ch = 2'd2; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cur_lvl      = lvl[ch];
    cur_tgt      = tgt[ch];
    match_nx     = match;
    match_nx[ch] = (nxt_lvl == cur_tgt);
  end

  fade_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .level      (cur_lvl),
    .target     (cur_tgt),
    .next_level (nxt_lvl)
  );

  // Per-channel match flags remember each landing so settled reflects the targets seen in this sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      state   <= IDLE;
      match   <= '0;
      settled <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) lvl[i] <= '0;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      state <= state_nx;
      if (upd) begin
        lvl[ch] <= nxt_lvl;
        match   <= match_nx;
      end
      if (state == UPD2) settled <= &match_nx;
    end
  end

endmodule
